reg_file_wr_demux: RTL and testbench



---
 rtl/reg_file_wr_demux_pkg.sv | 15 +
 rtl/reg_file_wr_demux_wr_demux_1to32.sv | 26 ++
 rtl/reg_file_wr_demux.sv | 96 +++++++++
 tb/tb_reg_file_wr_demux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_wr_demux_pkg.sv
// Shared definitions for the register file and its write demultiplexer.
// Holds the register-file geometry, the reserved zero-register address, and
// the address/data word typedefs used across the block.
package reg_file_wr_demux_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_DW   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] data_word_t;

endpackage : reg_file_wr_demux_pkg

// File: rtl/reg_file_wr_demux_wr_demux_1to32.sv
// Write-address demultiplexer: turns (we, wa) into a one-hot register enable.
// Ports:
//   i_we    write enable
//   i_wa    write address
//   o_en_c  combinational one-hot enable, bit 0 always 0 (register 0 is read-only)
module wr_demux_1to32
    import reg_file_wr_demux_pkg::*;
#(
    parameter int unsigned AW = REG_AW
) (
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    output logic [(1<<AW)-1:0] o_en_c
);

    // With we low the address is never used, so an unknown address cannot
    // reach the enable vector.
    always_comb begin
        o_en_c = '0;
        if (i_we) begin
            o_en_c[i_wa] = 1'b1;
        end
        o_en_c[0] = 1'b0;
    end

endmodule : wr_demux_1to32

// File: rtl/reg_file_wr_demux.sv
// 2**AW x DW general-purpose register file with a demultiplexed write port,
// two combinational read ports and register 0 hardwired to zero.
// Ports:
//   i_clk           clock, state updates on the rising edge
//   i_rst           synchronous active-high reset, clears every register
//   i_we/i_wa/i_wd  write enable, address and data
//   i_ra1/i_ra2     read addresses
//   o_rd1/o_rd2     combinational read data (optional same-cycle write bypass)
//   o_wr_hit        registered, high the cycle after a write that changed a register
module reg_file_wr_demux
    import reg_file_wr_demux_pkg::*;
#(
    parameter int unsigned DW     = REG_DW,
    parameter int unsigned AW     = REG_AW,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2,
    output logic          o_wr_hit
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DEPTH-1:0] w_en;
    logic [DW-1:0]    r_regs [DEPTH];
    logic             r_wr_hit;
    logic [DW-1:0]    w_rd1;
    logic [DW-1:0]    w_rd2;

    // Write demux; enable bit 0 is always clear.
    wr_demux_1to32 #(
        .AW (AW)
    ) u_wr_demux (
        .i_we   (i_we),
        .i_wa   (i_wa),
        .o_en_c (w_en)
    );

    // Storage: reset beats any write in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (w_en[i]) begin
                    r_regs[i] <= i_wd;
                end
            end
        end
    end

    // Write-hit flag: any set enable bit is a qualifying (nonzero-address) write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_hit <= 1'b0;
        end else begin
            r_wr_hit <= |w_en;
        end
    end

    // Read port 1; w_en[ra] implies we=1 and wa==ra!=0.
    always_comb begin
        w_rd1 = '0;
        if (i_ra1 != REG_ZERO) begin
            w_rd1 = r_regs[i_ra1];
        end
        if (BYPASS && !i_rst && w_en[i_ra1]) begin
            w_rd1 = i_wd;
        end
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        w_rd2 = '0;
        if (i_ra2 != REG_ZERO) begin
            w_rd2 = r_regs[i_ra2];
        end
        if (BYPASS && !i_rst && w_en[i_ra2]) begin
            w_rd2 = i_wd;
        end
    end

    assign o_rd1    = w_rd1;
    assign o_rd2    = w_rd2;
    assign o_wr_hit = r_wr_hit;

endmodule : reg_file_wr_demux

// File: tb/tb_reg_file_wr_demux.sv
// Directed bench for reg_file_wr_demux: one instance with bypass, one without,
// driven by the same inputs.
module tb_reg_file_wr_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        hit_b, hit_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_wr_demux #(.DW(32), .AW(5), .BYPASS(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_wa(wa), .i_wd(wd),
        .i_ra1(ra1), .i_ra2(ra2), .o_rd1(rd1_b), .o_rd2(rd2_b), .o_wr_hit(hit_b)
    );

    reg_file_wr_demux #(.DW(32), .AW(5), .BYPASS(1'b0)) u_dut_nb (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_wa(wa), .i_wd(wd),
        .i_ra1(ra1), .i_ra2(ra2), .o_rd1(rd1_n), .o_rd2(rd2_n), .o_wr_hit(hit_n)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            failures++; $display("FAIL reset_read got %h/%h want 0", rd1_b, rd2_b);
        end
        checks++;
        if (hit_b !== 1'b0 || hit_n !== 1'b0) begin
            failures++; $display("FAIL reset_hit got %b/%b want 0", hit_b, hit_n);
        end
        // Preload r5, then reset again.
        we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
        tick();
        we = 1'b0; ra1 = 5'd5;
        #1;
        checks++;
        if (rd1_n !== 32'h1234_5678) begin
            failures++; $display("FAIL preload_r5 got %h want 12345678", rd1_n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            failures++; $display("FAIL reset_clears_r5 got %h/%h want 0", rd1_b, rd1_n);
        end
        checks++;
        if (hit_b !== 1'b0) begin
            failures++; $display("FAIL reset_hit_after got %b want 0", hit_b);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF; ra1 = 5'd0; ra2 = 5'd0;
        tick();
        we = 1'b0; ra1 = 5'd3; ra2 = 5'd3;
        #1;
        checks++;
        if (rd1_b !== 32'hDEAD_BEEF || rd2_b !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_rd got %h/%h want deadbeef", rd1_b, rd2_b);
        end
        checks++;
        if (rd1_n !== 32'hDEAD_BEEF || rd2_n !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_rd_nb got %h/%h want deadbeef", rd1_n, rd2_n);
        end
        checks++;
        if (hit_b !== 1'b1 || hit_n !== 1'b1) begin
            failures++; $display("FAIL wr_hit_set got %b/%b want 1", hit_b, hit_n);
        end
        tick();
        checks++;
        if (hit_b !== 1'b0 || hit_n !== 1'b0) begin
            failures++; $display("FAIL wr_hit_pulse got %b/%b want 0", hit_b, hit_n);
        end
    endtask

    task automatic test_reg_zero();
        ra1 = 5'd0; ra2 = 5'd0; we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
            failures++; $display("FAIL r0_bypass got %h/%h want 0", rd1_b, rd2_b);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            failures++; $display("FAIL r0_after got %h/%h want 0", rd1_b, rd1_n);
        end
        checks++;
        if (hit_b !== 1'b0 || hit_n !== 1'b0) begin
            failures++; $display("FAIL r0_hit got %b/%b want 0", hit_b, hit_n);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        tick();
        wd = 32'h2; ra1 = 5'd7; ra2 = 5'd7;
        #1;
        checks++;
        if (rd1_b !== 32'h2 || rd2_b !== 32'h2) begin
            failures++; $display("FAIL bypass_on got %h/%h want 2", rd1_b, rd2_b);
        end
        checks++;
        if (rd1_n !== 32'h1 || rd2_n !== 32'h1) begin
            failures++; $display("FAIL bypass_off_pre got %h/%h want 1", rd1_n, rd2_n);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1_n !== 32'h2 || rd1_b !== 32'h2) begin
            failures++; $display("FAIL bypass_off_post got %h/%h want 2", rd1_n, rd1_b);
        end
        // No bypass while reset is asserted: old r7 value is seen.
        rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h3;
        #1;
        checks++;
        if (rd1_b !== 32'h2) begin
            failures++; $display("FAIL bypass_in_rst got %h want 2", rd1_b);
        end
        tick();
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_rst_we_collision();
        rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hA5A5_A5A5; ra1 = 5'd9; ra2 = 5'd7;
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            failures++; $display("FAIL collision_r9 got %h/%h want 0", rd1_b, rd1_n);
        end
        checks++;
        if (hit_b !== 1'b0 || hit_n !== 1'b0) begin
            failures++; $display("FAIL collision_hit got %b/%b want 0", hit_b, hit_n);
        end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; wa = 5'd4; wd = 32'h11; ra1 = 5'd4; ra2 = 5'd4;
        tick();
        checks++;
        if (rd1_n !== 32'h11 || hit_n !== 1'b1) begin
            failures++; $display("FAIL b2b_first got %h/%b want 11/1", rd1_n, hit_n);
        end
        wd = 32'h22;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1_n !== 32'h22 || rd2_b !== 32'h22 || hit_n !== 1'b1) begin
            failures++; $display("FAIL b2b_second got %h/%h/%b want 22/22/1", rd1_n, rd2_b, hit_n);
        end
        // First write after a reset behaves normally.
        rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'h33;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1_n !== 32'h33 || hit_n !== 1'b1) begin
            failures++; $display("FAIL post_rst_write got %h/%b want 33/1", rd1_n, hit_n);
        end
    endtask

    task automatic test_walking();
        logic [31:0] exp1, exp2;
        int bad;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h0101_0101;
            tick();
        end
        we = 1'b0; wa = 'x; wd = 'x;
        tick();
        tick();
        checks++;
        if (hit_b !== 1'b0 || hit_n !== 1'b0) begin
            failures++; $display("FAIL walk_idle_hit got %b/%b want 0", hit_b, hit_n);
        end
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(32 - i);
            exp1 = 32'(i) * 32'h0101_0101;
            exp2 = 32'(32 - i) * 32'h0101_0101;
            #1;
            checks++;
            if (rd1_b !== exp1 || rd2_b !== exp2 || rd1_n !== exp1 || rd2_n !== exp2) begin
                failures++; bad++;
                $display("FAIL walk_r%0d got %h/%h/%h/%h want %h/%h",
                         i, rd1_b, rd2_b, rd1_n, rd2_n, exp1, exp2);
            end
        end
        wa = '0; wd = '0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg_zero();
        test_bypass();
        test_rst_we_collision();
        test_back_to_back();
        test_walking();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_wr_demux
